// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared widths, size/exception codes and FSM states
// Purpose: common definitions for the MEM-stage load/store unit.
// Ports: none (package).
package mem_access_unit_pkg;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 64;
  localparam int STRB_W = XLEN / 8;

  // access size codes
  localparam logic [1:0] LS_B = 2'b00;
  localparam logic [1:0] LS_H = 2'b01;
  localparam logic [1:0] LS_W = 2'b10;
  localparam logic [1:0] LS_D = 2'b11;

  // exception codes: bit1 = fault (vs misalign), bit0 = store (vs load)
  localparam logic [1:0] EXC_LD_MISALIGN = 2'b00;
  localparam logic [1:0] EXC_ST_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_LD_FAULT    = 2'b10;
  localparam logic [1:0] EXC_ST_FAULT    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RSP  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // natural alignment check on the low address bits
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      LS_H:    mis = off[0];
      LS_W:    mis = |off[1:0];
      LS_D:    mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - EXE op, data-memory bus and writeback signal bundle
// Purpose: groups the handshake/bus signals of mem_access_unit.
// Ports (master = the unit, slave = its environment):
//   ls_*      op from EXE (valid/ready handshake)
//   mem_req_* request to data memory (valid/ready handshake)
//   mem_rsp_* response from data memory
//   mem_r_data/rd_data_mem_ena/mem_rd_addr  writeback
//   mem_stall, exc_valid/exc_code           pipeline control and exceptions
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic              ls_valid;
  logic              ls_ready;
  logic              ls_is_load;
  logic [1:0]        ls_size;
  logic              ls_unsigned;
  logic [ADDR_W-1:0] ls_addr;
  logic [XLEN-1:0]   ls_wdata;
  logic [4:0]        ls_rd;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [STRB_W-1:0] mem_req_wmask;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_rdata;
  logic              mem_rsp_err;

  logic [XLEN-1:0]   mem_r_data;
  logic              rd_data_mem_ena;
  logic [4:0]        mem_rd_addr;
  logic              mem_stall;
  logic              exc_valid;
  logic [1:0]        exc_code;

  modport master (
    input  ls_valid, ls_is_load, ls_size, ls_unsigned, ls_addr, ls_wdata, ls_rd,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    output ls_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
           mem_req_wmask, mem_r_data, rd_data_mem_ena, mem_rd_addr, mem_stall,
           exc_valid, exc_code
  );

  modport slave (
    output ls_valid, ls_is_load, ls_size, ls_unsigned, ls_addr, ls_wdata, ls_rd,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    input  ls_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
           mem_req_wmask, mem_r_data, rd_data_mem_ena, mem_rd_addr, mem_stall,
           exc_valid, exc_code
  );

endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// rtl/mem_access_unit_lsu_align.sv - store data/strobe placement and load lane extraction
// Purpose: combinational byte-lane alignment for the load/store unit.
// Ports:
//   size_i, unsigned_i, is_load_i, off_i  access attributes and byte offset
//   wdata_i / wdata_o                    right-aligned store data / lane-shifted store data
//   wmask_o                              byte strobes (zero for loads)
//   rdata_i / ldata_o                    raw doubleword / aligned, extended load value
module lsu_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic              is_load_i,
  input  logic [2:0]        off_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [XLEN-1:0]   wdata_o,
  output logic [STRB_W-1:0] wmask_o,
  output logic [XLEN-1:0]   ldata_o
);

  logic [5:0]        bit_sh;
  logic [STRB_W-1:0] base_mask;
  logic [XLEN-1:0]   lane;
  logic              sx;

  assign bit_sh  = {off_i, 3'b000};
  assign wdata_o = wdata_i << bit_sh;
  assign lane    = rdata_i >> bit_sh;

  always_comb begin
    base_mask = '0;
    ldata_o   = lane;
    sx        = 1'b0;
    case (size_i)
      LS_B: begin
        base_mask = 8'h01;
        sx        = ~unsigned_i & lane[7];
        ldata_o   = {{(XLEN-8){sx}}, lane[7:0]};
      end
      LS_H: begin
        base_mask = 8'h03;
        sx        = ~unsigned_i & lane[15];
        ldata_o   = {{(XLEN-16){sx}}, lane[15:0]};
      end
      LS_W: begin
        base_mask = 8'h0F;
        sx        = ~unsigned_i & lane[31];
        ldata_o   = {{(XLEN-32){sx}}, lane[31:0]};
      end
      default: begin
        // dword: full lane, signedness is irrelevant
        base_mask = 8'hFF;
        ldata_o   = lane;
      end
    endcase
  end

  assign wmask_o = is_load_i ? '0 : (base_mask << off_i);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine driving the data-memory bus
// Purpose: accepts one load/store from EXE, runs a single bus transaction,
//   and returns aligned load data to writeback or raises an exception.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  mem_access_unit_if.master (EXE op, memory request/response, writeback,
//        stall and exception outputs)
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.master bus
);

  state_t            state_q;
  logic              ls_ready_q, mem_stall_q;
  logic              is_load_q, unsigned_q;
  logic [1:0]        size_q;
  logic [2:0]        off_q;
  logic [4:0]        rd_q;
  logic              mem_req_valid_q, mem_req_we_q;
  logic [ADDR_W-1:0] mem_req_addr_q;
  logic [XLEN-1:0]   mem_req_wdata_q;
  logic [STRB_W-1:0] mem_req_wmask_q;
  logic [XLEN-1:0]   mem_r_data_q;
  logic              rd_data_mem_ena_q;
  logic [4:0]        mem_rd_addr_q;
  logic              exc_valid_q;
  logic [1:0]        exc_code_q;

  // In IDLE the aligner sees the incoming op so request fields can be
  // registered on accept; afterwards it sees the latched op for load extraction.
  logic              idle;
  logic [1:0]        al_size;
  logic              al_unsigned, al_is_load;
  logic [2:0]        al_off;
  logic [XLEN-1:0]   al_wdata, al_ldata;
  logic [STRB_W-1:0] al_wmask;

  assign idle        = (state_q == ST_IDLE);
  assign al_size     = idle ? bus.ls_size     : size_q;
  assign al_unsigned = idle ? bus.ls_unsigned : unsigned_q;
  assign al_is_load  = idle ? bus.ls_is_load  : is_load_q;
  assign al_off      = idle ? bus.ls_addr[2:0] : off_q;

  lsu_align u_align (
    .size_i     (al_size),
    .unsigned_i (al_unsigned),
    .is_load_i  (al_is_load),
    .off_i      (al_off),
    .wdata_i    (bus.ls_wdata),
    .rdata_i    (bus.mem_rsp_rdata),
    .wdata_o    (al_wdata),
    .wmask_o    (al_wmask),
    .ldata_o    (al_ldata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      ls_ready_q        <= 1'b1;
      mem_stall_q       <= 1'b0;
      is_load_q         <= 1'b0;
      unsigned_q        <= 1'b0;
      size_q            <= LS_B;
      off_q             <= '0;
      rd_q              <= '0;
      mem_req_valid_q   <= 1'b0;
      mem_req_we_q      <= 1'b0;
      mem_req_addr_q    <= '0;
      mem_req_wdata_q   <= '0;
      mem_req_wmask_q   <= '0;
      mem_r_data_q      <= '0;
      rd_data_mem_ena_q <= 1'b0;
      mem_rd_addr_q     <= '0;
      exc_valid_q       <= 1'b0;
      exc_code_q        <= '0;
    end else begin
      rd_data_mem_ena_q <= 1'b0;
      exc_valid_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.ls_valid && ls_ready_q) begin
            is_load_q  <= bus.ls_is_load;
            unsigned_q <= bus.ls_unsigned;
            size_q     <= bus.ls_size;
            off_q      <= bus.ls_addr[2:0];
            rd_q       <= bus.ls_rd;
            if (is_misaligned(bus.ls_size, bus.ls_addr[2:0])) begin
              // no bus access; unit stays ready
              exc_valid_q <= 1'b1;
              exc_code_q  <= bus.ls_is_load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
            end else begin
              state_q         <= ST_REQ;
              ls_ready_q      <= 1'b0;
              mem_stall_q     <= 1'b1;
              mem_req_valid_q <= 1'b1;
              mem_req_we_q    <= ~bus.ls_is_load;
              mem_req_addr_q  <= {bus.ls_addr[ADDR_W-1:3], 3'b000};
              mem_req_wdata_q <= al_wdata;
              mem_req_wmask_q <= al_wmask;
            end
          end
        end
        ST_REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (bus.mem_rsp_valid) begin
            if (bus.mem_rsp_err) begin
              exc_valid_q <= 1'b1;
              exc_code_q  <= is_load_q ? EXC_LD_FAULT : EXC_ST_FAULT;
              state_q     <= ST_IDLE;
              ls_ready_q  <= 1'b1;
              mem_stall_q <= 1'b0;
            end else if (is_load_q) begin
              mem_r_data_q      <= al_ldata;
              mem_rd_addr_q     <= rd_q;
              rd_data_mem_ena_q <= 1'b1;
              state_q           <= ST_DONE;
            end else begin
              state_q     <= ST_IDLE;
              ls_ready_q  <= 1'b1;
              mem_stall_q <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          ls_ready_q  <= 1'b1;
          mem_stall_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ls_ready        = ls_ready_q;
  assign bus.mem_stall       = mem_stall_q;
  assign bus.mem_req_valid   = mem_req_valid_q;
  assign bus.mem_req_we      = mem_req_we_q;
  assign bus.mem_req_addr    = mem_req_addr_q;
  assign bus.mem_req_wdata   = mem_req_wdata_q;
  assign bus.mem_req_wmask   = mem_req_wmask_q;
  assign bus.mem_r_data      = mem_r_data_q;
  assign bus.rd_data_mem_ena = rd_data_mem_ena_q;
  assign bus.mem_rd_addr     = mem_rd_addr_q;
  assign bus.exc_valid       = exc_valid_q;
  assign bus.exc_code        = exc_code_q;

endmodule
